// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with synchronous load and wrap pulse,
// plus an independent one-stage Gray-to-binary decoder.
module gray_counter #(
    parameter int WIDTH = 10,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    input  logic             dec_valid_in,
    input  logic [WIDTH-1:0] dec_gray_in,
    output logic             dec_valid_out,
    output logic [WIDTH-1:0] dec_bin_out
);

    localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ONE_B  = WIDTH'(1);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] r_bin_p1;
    logic [WIDTH-1:0] r_gray_p1;
    logic             r_wrap_p1;
    logic             r_dec_vld_p1;
    logic [WIDTH-1:0] r_dec_bin_p1;

    logic [WIDTH-1:0] w_bin_nxt;
    logic             w_wrap_nxt;

    always_comb begin
        w_bin_nxt  = r_bin_p1;
        w_wrap_nxt = 1'b0;
        if (load) begin
            w_bin_nxt = load_value;
        end else if (en) begin
            if (up) begin
                w_bin_nxt  = r_bin_p1 + ONE_B;
                w_wrap_nxt = (r_bin_p1 == '1);
            end else begin
                w_bin_nxt  = r_bin_p1 - ONE_B;
                w_wrap_nxt = (r_bin_p1 == '0);
            end
        end
    end

    // p0 -> p1: Gray is encoded from the next binary value so both flop together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin_p1  <= INIT_B;
            r_gray_p1 <= bin2gray(INIT_B);
            r_wrap_p1 <= 1'b0;
        end else begin
            r_bin_p1  <= w_bin_nxt;
            r_gray_p1 <= bin2gray(w_bin_nxt);
            r_wrap_p1 <= w_wrap_nxt;
        end
    end

    // p0 -> p1: decoder stage, data held while the qualifier is low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec_vld_p1 <= 1'b0;
            r_dec_bin_p1 <= '0;
        end else begin
            r_dec_vld_p1 <= dec_valid_in;
            if (dec_valid_in) begin
                r_dec_bin_p1 <= gray2bin(dec_gray_in);
            end
        end
    end

    assign bin_out       = r_bin_p1;
    assign gray_out      = r_gray_p1;
    assign wrap          = r_wrap_p1;
    assign dec_valid_out = r_dec_vld_p1;
    assign dec_bin_out   = r_dec_bin_p1;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed vector table, decoder sequences,
// exhaustive walk and randomized traffic against a reflected-code reference model.
module tb_gray_counter;

    localparam int W = 10;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] bin_out;
    logic [W-1:0] gray_out;
    logic         wrap;
    logic         dec_valid_in = 1'b0;
    logic [W-1:0] dec_gray_in = '0;
    logic         dec_valid_out;
    logic [W-1:0] dec_bin_out;

    gray_counter #(.WIDTH(W), .INIT(0)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_value(load_value), .bin_out(bin_out), .gray_out(gray_out),
        .wrap(wrap), .dec_valid_in(dec_valid_in), .dec_gray_in(dec_gray_in),
        .dec_valid_out(dec_valid_out), .dec_bin_out(dec_bin_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference Gray table built by reflection, and its inverse for decoding
    int gtab[N];
    int ginv[N];

    typedef struct {
        logic         rst;
        logic         ld;
        logic [W-1:0] ldv;
        logic         e;
        logic         u;
        logic [W-1:0] exp_bin;
        logic [W-1:0] exp_gray;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev_gray;
        int wraps;
        int m_bin, m_wrap, m_dvld, m_dbin;
        int exp_b;
        int exp_w;

        gtab[0] = 0;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | (1 << k);
            end
        end
        for (int i = 0; i < N; i++) ginv[gtab[i]] = i;

        vecs[0]  = '{1, 0, 10'h000, 0, 0, 10'h000, 10'h000, 0};
        vecs[1]  = '{0, 0, 10'h000, 1, 1, 10'h001, 10'h001, 0};
        vecs[2]  = '{0, 0, 10'h000, 1, 1, 10'h002, 10'h003, 0};
        vecs[3]  = '{0, 0, 10'h000, 1, 1, 10'h003, 10'h002, 0};
        vecs[4]  = '{0, 1, 10'h3FF, 0, 0, 10'h3FF, 10'h200, 0};
        vecs[5]  = '{0, 0, 10'h000, 1, 1, 10'h000, 10'h000, 1};
        vecs[6]  = '{0, 0, 10'h000, 0, 0, 10'h000, 10'h000, 0};
        vecs[7]  = '{0, 0, 10'h000, 1, 0, 10'h3FF, 10'h200, 1};
        vecs[8]  = '{0, 0, 10'h000, 1, 0, 10'h3FE, 10'h201, 0};
        vecs[9]  = '{0, 1, 10'h155, 1, 1, 10'h155, 10'h1FF, 0};
        vecs[10] = '{0, 0, 10'h000, 0, 1, 10'h155, 10'h1FF, 0};
        vecs[11] = '{1, 1, 10'h2AA, 1, 1, 10'h000, 10'h000, 0};

        for (int i = 0; i < 12; i++) begin
            reset = vecs[i].rst; load = vecs[i].ld; load_value = vecs[i].ldv;
            en = vecs[i].e; up = vecs[i].u;
            tick();
            check($sformatf("vec%0d_bin", i), int'(bin_out), int'(vecs[i].exp_bin));
            check($sformatf("vec%0d_gray", i), int'(gray_out), int'(vecs[i].exp_gray));
            check($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
            if (i == 0) begin
                check("rst_dec_vld", int'(dec_valid_out), 0);
                check("rst_dec_bin", int'(dec_bin_out), 0);
            end
        end
        reset = 0; load = 0; en = 0; up = 0;

        // Decoder directed stream
        dec_valid_in = 1; dec_gray_in = 10'h200; tick();
        check("dec0_vld", int'(dec_valid_out), 1); check("dec0_bin", int'(dec_bin_out), 'h3FF);
        dec_gray_in = 10'h001; tick();
        check("dec1_vld", int'(dec_valid_out), 1); check("dec1_bin", int'(dec_bin_out), 'h001);
        dec_gray_in = 10'h1FF; tick();
        check("dec2_vld", int'(dec_valid_out), 1); check("dec2_bin", int'(dec_bin_out), 'h155);
        dec_valid_in = 0; dec_gray_in = 10'h0F0; tick();
        check("dec_idle_vld", int'(dec_valid_out), 0); check("dec_hold_bin", int'(dec_bin_out), 'h155);
        tick();
        check("dec_hold2_bin", int'(dec_bin_out), 'h155);
        dec_valid_in = 1; dec_gray_in = 10'h3C3; reset = 1; tick();
        check("dec_rst_vld", int'(dec_valid_out), 0); check("dec_rst_bin", int'(dec_bin_out), 0);
        dec_valid_in = 0; reset = 0;

        // Exhaustive walk: up then down from 0
        prev_gray = int'(gray_out);
        wraps = 0;
        en = 1; up = 1;
        for (int s = 0; s < N; s++) begin
            tick();
            check("walk_up_1bit", $countones(int'(gray_out) ^ prev_gray), 1);
            check("walk_up_gray", int'(gray_out), gtab[int'(bin_out)]);
            check("walk_up_bin", int'(bin_out), (s + 1) % N);
            wraps += int'(wrap);
            prev_gray = int'(gray_out);
        end
        check("walk_up_wraps", wraps, 1);
        wraps = 0; up = 0;
        for (int s = 0; s < N; s++) begin
            tick();
            check("walk_dn_1bit", $countones(int'(gray_out) ^ prev_gray), 1);
            check("walk_dn_gray", int'(gray_out), gtab[int'(bin_out)]);
            check("walk_dn_bin", int'(bin_out), (N - 1 - s) % N);
            wraps += int'(wrap);
            prev_gray = int'(gray_out);
        end
        check("walk_dn_wraps", wraps, 1);

        // Randomized traffic against the reference model
        m_bin = int'(bin_out); m_dvld = int'(dec_valid_out); m_dbin = int'(dec_bin_out);
        for (int c = 0; c < 2000; c++) begin
            reset        = ($urandom_range(0, 49) == 0);
            load         = ($urandom_range(0, 9) == 0);
            load_value   = W'($urandom);
            en           = ($urandom_range(0, 3) != 0);
            up           = $urandom_range(0, 1) == 1;
            dec_valid_in = $urandom_range(0, 1) == 1;
            dec_gray_in  = W'($urandom);
            if (($urandom_range(0, 7) == 0)) load_value = ($urandom_range(0, 1) == 1) ? '1 : '0;
            exp_w = 0;
            if (reset) begin
                exp_b = 0;
            end else if (load) begin
                exp_b = int'(load_value);
            end else if (en && up) begin
                exp_b = (m_bin + 1) % N; exp_w = (m_bin == N - 1);
            end else if (en) begin
                exp_b = (m_bin + N - 1) % N; exp_w = (m_bin == 0);
            end else begin
                exp_b = m_bin;
            end
            if (reset) begin
                m_dvld = 0; m_dbin = 0;
            end else begin
                m_dvld = int'(dec_valid_in);
                if (dec_valid_in) m_dbin = ginv[int'(dec_gray_in)];
            end
            m_bin = exp_b; m_wrap = exp_w;
            tick();
            check("rnd_bin", int'(bin_out), m_bin);
            check("rnd_gray", int'(gray_out), gtab[m_bin]);
            check("rnd_wrap", int'(wrap), m_wrap);
            check("rnd_dec_vld", int'(dec_valid_out), m_dvld);
            check("rnd_dec_bin", int'(dec_bin_out), m_dbin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
